// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master/slave pair: FSM states, frame size default
// and the bus mode both ends agree on.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } spi_state_t;

    localparam int DEFAULT_FRAME_BITS = 32;

    // Mode 0: sck idles low, data sampled on the rising edge, changed on the falling edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_sck_gen.sv
// Half-period divider for the SPI master: produces registered sck plus rise/fall
// strobes; the first strobe fires on the first clk edge after enable.
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic stop,
    output logic sck,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam int DW = $clog2(CLK_DIV) + 1;

    logic [DW-1:0] div;

    // A tick marks the end of a half period; stop suppresses the rise that
    // would otherwise follow the final low half period.
    assign tick = en && (div == '0);
    assign rise = tick && (sck == SPI_CPOL) && !stop;
    assign fall = tick && (sck != SPI_CPOL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= '0;
        end else if (!en) begin
            div <= '0;
        end else if (div == DW'(CLK_DIV - 1)) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck <= SPI_CPOL;
        end else if (!en) begin
            sck <= SPI_CPOL;
        end else if (rise) begin
            sck <= ~SPI_CPOL;
        end else if (fall) begin
            sck <= SPI_CPOL;
        end
    end

endmodule

// File: rtl/spi_master_frame.sv
// Fixed-length SPI master frame engine: start/busy/done handshake on the fabric
// side, mode-0 sck/mosi/miso/cs_n on the pin side.
module spi_master_frame
    import spi_pkg::*;
#(
    parameter int FRAME_BITS = DEFAULT_FRAME_BITS,
    parameter int CLK_DIV    = 4,
    parameter int IDLE_GAP   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_n
);

    localparam int BW       = $clog2(FRAME_BITS) + 1;
    localparam int WAIT_MAX = (CLK_DIV > IDLE_GAP) ? CLK_DIV : IDLE_GAP;
    localparam int WW       = $clog2(WAIT_MAX + 1) + 1;
    localparam int GAP_LAST = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;

    spi_state_t            state;
    spi_state_t            next_state;
    logic [FRAME_BITS-1:0] tx_shreg;
    logic [FRAME_BITS-1:0] rx_shreg;
    logic [BW-1:0]         bit_cnt;
    logic [WW-1:0]         wait_cnt;
    logic                  sck_en;
    logic                  last_bit;
    logic                  sck_tick;
    logic                  sck_rise;
    logic                  sck_fall;
    logic                  accept;
    logic                  setup_done;
    logic                  gap_done;
    logic                  frame_end;

    spi_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk  (clk),
        .reset(reset),
        .en   (sck_en),
        .stop (last_bit),
        .sck  (sck),
        .tick (sck_tick),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)     next_state = SETUP;
            SETUP:   if (setup_done) next_state = SHIFT;
            SHIFT:   if (frame_end)  next_state = (IDLE_GAP == 0) ? IDLE : GAP;
            GAP:     if (gap_done)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The frame ends on the tick that closes the low half period after the last bit.
    always_comb begin
        busy       = (state != IDLE);
        sck_en     = (state == SHIFT);
        last_bit   = (bit_cnt == BW'(FRAME_BITS));
        accept     = (state == IDLE) && start;
        setup_done = (state == SETUP) && (wait_cnt == WW'(CLK_DIV - 1));
        gap_done   = (state == GAP) && (wait_cnt == WW'(GAP_LAST));
        frame_end  = (state == SHIFT) && sck_tick && !sck && last_bit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != next_state) begin
            wait_cnt <= '0;
        end else if (state == SETUP || state == GAP) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // The MSB goes out with the cs_n fall; each later bit follows an sck fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_shreg <= '0;
            rx_shreg <= '0;
            rx_data  <= '0;
            bit_cnt  <= '0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= frame_end;
            if (accept) begin
                tx_shreg <= tx_data;
                mosi     <= tx_data[FRAME_BITS-1];
                cs_n     <= 1'b0;
                bit_cnt  <= '0;
            end
            if (sck_rise) begin
                rx_shreg <= {rx_shreg[FRAME_BITS-2:0], miso};
                bit_cnt  <= bit_cnt + 1'b1;
            end
            if (sck_fall) begin
                tx_shreg <= tx_shreg << 1;
                mosi     <= last_bit ? 1'b0 : tx_shreg[FRAME_BITS-2];
            end
            if (frame_end) begin
                cs_n    <= 1'b1;
                rx_data <= rx_shreg;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_frame.sv
// Directed bench for spi_master_frame: a 32-bit/div-2 instance with a loopback or
// scripted slave, and an 8-bit/div-1 instance with no idle gap.
module tb_spi_master_frame;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;

    logic        start_a = 1'b0;
    logic [31:0] tx_a    = '0;
    logic [31:0] rx_a;
    logic        busy_a, done_a, sck_a, mosi_a, miso_a, cs_n_a;
    logic        loop_a  = 1'b1;
    logic [31:0] slave_word_a = '0;

    logic        start_b = 1'b0;
    logic [7:0]  tx_b    = '0;
    logic [7:0]  rx_b;
    logic        busy_b, done_b, sck_b, mosi_b, miso_b, cs_n_b;

    int errors = 0;
    int checks = 0;

    int   frame_rises_a = 0;
    int   rise_total_a  = 0;
    int   done_cnt_a    = 0;
    int   mosi_high_a   = 0;
    int   mosi_viol_a   = 0;
    int   toggles_b     = 0;
    logic prev_sck_a    = 1'b0;
    logic prev_cs_n_a   = 1'b1;
    logic prev_mosi_a   = 1'b0;
    logic prev_sck_b    = 1'b0;

    always #5 clk = ~clk;

    spi_master_frame #(.FRAME_BITS(32), .CLK_DIV(2), .IDLE_GAP(4)) dut_a (
        .clk    (clk),
        .reset  (reset),
        .start  (start_a),
        .tx_data(tx_a),
        .rx_data(rx_a),
        .busy   (busy_a),
        .done   (done_a),
        .sck    (sck_a),
        .mosi   (mosi_a),
        .miso   (miso_a),
        .cs_n   (cs_n_a)
    );

    spi_master_frame #(.FRAME_BITS(8), .CLK_DIV(1), .IDLE_GAP(0)) dut_b (
        .clk    (clk),
        .reset  (reset),
        .start  (start_b),
        .tx_data(tx_b),
        .rx_data(rx_b),
        .busy   (busy_b),
        .done   (done_b),
        .sck    (sck_b),
        .mosi   (mosi_b),
        .miso   (miso_b),
        .cs_n   (cs_n_b)
    );

    // Scripted slave presents the next response bit right after each sampling edge.
    assign miso_a = loop_a ? mosi_a
                  : ((frame_rises_a < 32) ? slave_word_a[31 - frame_rises_a] : 1'b0);
    assign miso_b = mosi_b;

    always @(posedge sck_a or posedge cs_n_a) begin
        if (cs_n_a) begin
            frame_rises_a = 0;
        end else begin
            frame_rises_a = frame_rises_a + 1;
            rise_total_a  = rise_total_a + 1;
        end
    end

    // mosi may only move on an sck fall, on the cs_n fall that opens a frame, or under reset.
    always @(negedge clk) begin
        if (done_a) done_cnt_a = done_cnt_a + 1;
        if (mosi_a) mosi_high_a = mosi_high_a + 1;
        if ((mosi_a !== prev_mosi_a) && !reset && !(prev_sck_a && !sck_a) && !(prev_cs_n_a && !cs_n_a))
            mosi_viol_a = mosi_viol_a + 1;
        prev_mosi_a = mosi_a;
        prev_sck_a  = sck_a;
        prev_cs_n_a = cs_n_a;
        if (sck_b !== prev_sck_b) toggles_b = toggles_b + 1;
        prev_sck_b = sck_b;
    end

    task automatic launch_a(input logic [31:0] word);
        @(negedge clk);
        tx_a    = word;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                cyc = i;
                return;
            end
        end
        checks++;
        errors++;
        $display("[TB] FAIL wait_done_a: got no done within 2000 cycles, required one");
        cyc = -1;
    endtask

    task automatic wait_idle_a();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_a) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL wait_idle_a: busy still 1 after 100 cycles, required 0");
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cs_n_a !== 1'b1)  begin errors++; $display("[TB] FAIL reset_cs_n: got %b expected 1", cs_n_a); end
        checks++; if (sck_a !== 1'b0)   begin errors++; $display("[TB] FAIL reset_sck: got %b expected 0", sck_a); end
        checks++; if (mosi_a !== 1'b0)  begin errors++; $display("[TB] FAIL reset_mosi: got %b expected 0", mosi_a); end
        checks++; if (busy_a !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (done_a !== 1'b0)  begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done_a); end
        checks++; if (rx_a !== 32'h0)   begin errors++; $display("[TB] FAIL reset_rx: got %h expected 0", rx_a); end
        checks++; if (cs_n_b !== 1'b1)  begin errors++; $display("[TB] FAIL reset_cs_n_b: got %b expected 1", cs_n_b); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback();
        int cyc;
        int base_r;
        int base_v;
        loop_a = 1'b1;
        base_r = rise_total_a;
        base_v = mosi_viol_a;
        launch_a(32'hA5A500FF);
        wait_done_a(cyc);
        checks++; if (cyc !== 131)          begin errors++; $display("[TB] FAIL loop_latency: got %0d expected 131", cyc); end
        checks++; if (rx_a !== 32'hA5A500FF) begin errors++; $display("[TB] FAIL loop_rx: got %h expected a5a500ff", rx_a); end
        checks++; if (cs_n_a !== 1'b1)      begin errors++; $display("[TB] FAIL loop_cs_n_end: got %b expected 1", cs_n_a); end
        checks++; if (rise_total_a - base_r !== 32) begin errors++; $display("[TB] FAIL loop_sck_rises: got %0d expected 32", rise_total_a - base_r); end
        @(posedge clk);
        #1;
        checks++; if (done_a !== 1'b0)      begin errors++; $display("[TB] FAIL loop_done_width: got %b expected 0", done_a); end
        wait_idle_a();
        checks++; if (mosi_viol_a - base_v !== 0) begin errors++; $display("[TB] FAIL loop_mosi_stable: got %0d bad changes expected 0", mosi_viol_a - base_v); end
    endtask

    task automatic test_slave_response();
        int cyc;
        int base_h;
        int base_v;
        loop_a       = 1'b0;
        slave_word_a = 32'h000003FF;
        base_h = mosi_high_a;
        base_v = mosi_viol_a;
        launch_a(32'h0);
        wait_done_a(cyc);
        checks++; if (rx_a !== 32'h000003FF) begin errors++; $display("[TB] FAIL slave_rx: got %h expected 000003ff", rx_a); end
        checks++; if (cyc !== 131)           begin errors++; $display("[TB] FAIL slave_latency: got %0d expected 131", cyc); end
        wait_idle_a();
        checks++; if (mosi_high_a - base_h !== 0) begin errors++; $display("[TB] FAIL slave_mosi_zero: got %0d high samples expected 0", mosi_high_a - base_h); end
        checks++; if (mosi_viol_a - base_v !== 0) begin errors++; $display("[TB] FAIL slave_mosi_stable: got %0d bad changes expected 0", mosi_viol_a - base_v); end
    endtask

    task automatic test_start_ignored();
        int   cyc;
        int   dones   = 0;
        int   done_at = -1;
        logic busy_134 = 1'b0;
        logic busy_135 = 1'b1;
        loop_a = 1'b1;
        @(negedge clk);
        tx_a    = 32'h12345678;
        start_a = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 136; c++) begin
            @(negedge clk);
            start_a = (c == 10 || c == 134 || c == 136);
            tx_a    = (c == 136) ? 32'hCAFEF00D : $urandom;
            @(posedge clk);
            #1;
            if (done_a) begin
                dones++;
                done_at = c;
            end
            if (c == 134) busy_134 = busy_a;
            if (c == 135) busy_135 = busy_a;
        end
        checks++; if (dones !== 1)           begin errors++; $display("[TB] FAIL ign_done_count: got %0d expected 1", dones); end
        checks++; if (done_at !== 131)       begin errors++; $display("[TB] FAIL ign_done_cycle: got %0d expected 131", done_at); end
        checks++; if (rx_a !== 32'h12345678) begin errors++; $display("[TB] FAIL ign_rx_captured: got %h expected 12345678", rx_a); end
        checks++; if (busy_134 !== 1'b1)     begin errors++; $display("[TB] FAIL ign_busy_gap: got %b expected 1", busy_134); end
        checks++; if (busy_135 !== 1'b0)     begin errors++; $display("[TB] FAIL ign_busy_idle: got %b expected 0", busy_135); end
        checks++; if (cs_n_a !== 1'b0)       begin errors++; $display("[TB] FAIL ign_accept_cs_n: got %b expected 0", cs_n_a); end
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(cyc);
        checks++; if (rx_a !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL ign_second_rx: got %h expected cafef00d", rx_a); end
        wait_idle_a();
    endtask

    task automatic test_reset_abort();
        int cyc;
        int base_r;
        int base_d;
        int waited = 0;
        loop_a       = 1'b0;
        slave_word_a = 32'hDEADBEEF;
        base_r = rise_total_a;
        base_d = done_cnt_a;
        launch_a(32'hFFFFFFFF);
        while ((rise_total_a - base_r) < 10 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (rise_total_a - base_r !== 10) begin errors++; $display("[TB] FAIL abort_rise_point: got %0d rises expected 10", rise_total_a - base_r); end
        reset = 1'b1;
        #1;
        checks++; if (cs_n_a !== 1'b1) begin errors++; $display("[TB] FAIL abort_cs_n: got %b expected 1", cs_n_a); end
        checks++; if (sck_a !== 1'b0)  begin errors++; $display("[TB] FAIL abort_sck: got %b expected 0", sck_a); end
        checks++; if (mosi_a !== 1'b0) begin errors++; $display("[TB] FAIL abort_mosi: got %b expected 0", mosi_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy_a); end
        checks++; if (rx_a !== 32'h0)  begin errors++; $display("[TB] FAIL abort_rx: got %h expected 0", rx_a); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (done_cnt_a - base_d !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", done_cnt_a - base_d); end
        loop_a = 1'b1;
        launch_a(32'h0F0F1234);
        wait_done_a(cyc);
        checks++; if (cyc !== 131)           begin errors++; $display("[TB] FAIL abort_next_latency: got %0d expected 131", cyc); end
        checks++; if (rx_a !== 32'h0F0F1234) begin errors++; $display("[TB] FAIL abort_next_rx: got %h expected 0f0f1234", rx_a); end
        wait_idle_a();
    endtask

    task automatic test_back_to_back();
        int   t_done[3];
        int   runs[2];
        int   nd   = 0;
        int   nr   = 0;
        int   run  = 0;
        int   cyc  = 0;
        logic seen = 1'b0;
        runs[0] = -1;
        runs[1] = -1;
        loop_a = 1'b1;
        @(negedge clk);
        tx_a    = 32'h5A5A5A5A;
        start_a = 1'b1;
        while (nd < 3 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (done_a) begin
                t_done[nd] = cyc;
                nd++;
                seen = 1'b1;
            end
            if (seen) begin
                if (cs_n_a) begin
                    run++;
                end else if (run > 0) begin
                    if (nr < 2) runs[nr] = run;
                    nr++;
                    run = 0;
                end
            end
        end
        start_a = 1'b0;
        checks++; if (nd !== 3) begin errors++; $display("[TB] FAIL b2b_frames: got %0d done pulses expected 3", nd); end
        if (nd == 3) begin
            checks++; if (t_done[1] - t_done[0] !== 136) begin errors++; $display("[TB] FAIL b2b_spacing1: got %0d expected 136", t_done[1] - t_done[0]); end
            checks++; if (t_done[2] - t_done[1] !== 136) begin errors++; $display("[TB] FAIL b2b_spacing2: got %0d expected 136", t_done[2] - t_done[1]); end
        end
        checks++; if (runs[0] !== 5) begin errors++; $display("[TB] FAIL b2b_cs_high1: got %0d expected 5", runs[0]); end
        checks++; if (runs[1] !== 5) begin errors++; $display("[TB] FAIL b2b_cs_high2: got %0d expected 5", runs[1]); end
        checks++; if (rx_a !== 32'h5A5A5A5A) begin errors++; $display("[TB] FAIL b2b_rx: got %h expected 5a5a5a5a", rx_a); end
        wait_idle_a();
    endtask

    task automatic test_fast_clk();
        int cyc = -1;
        int base_t;
        base_t = toggles_b;
        @(negedge clk);
        tx_b    = 8'h81;
        start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (done_b) begin
                cyc = i;
                break;
            end
        end
        checks++; if (cyc !== 18)    begin errors++; $display("[TB] FAIL fast_latency: got %0d expected 18", cyc); end
        checks++; if (rx_b !== 8'h81) begin errors++; $display("[TB] FAIL fast_rx: got %h expected 81", rx_b); end
        checks++; if (toggles_b - base_t !== 16) begin errors++; $display("[TB] FAIL fast_sck_toggles: got %0d expected 16", toggles_b - base_t); end
        @(posedge clk);
        #1;
        checks++; if (busy_b !== 1'b0) begin errors++; $display("[TB] FAIL fast_no_gap_busy: got %b expected 0", busy_b); end
        checks++; if (cs_n_b !== 1'b1) begin errors++; $display("[TB] FAIL fast_cs_n_end: got %b expected 1", cs_n_b); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_slave_response();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_fast_clk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at 500000, required finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
